master_request_fifo: RTL and testbench
======================================

// Module: master_request_fifo
// PURPOSE
// - Per-master AXI address-channel request queue that sits directly upstream of each slave's forward arbiter.
// - Accepts AW or AR requests from one master port and decodes the destination slave at push time.
// - Presents the head entry, its destination index and an empty flag to all forward arbiters.
// - The crossbar pops the head once the granted slave accepts the request.
// PARAMETERS
// - slaves         2    number of slave ports; dest width = $clog2(slaves)
// - depth          4    queue entries; power of 2, >=2
// - addr_width     32   AxADDR width
// - id_width       4    AxID width
// - slave_sel_lsb  28   LSB of address field selecting the slave; field width = $clog2(slaves)
// PORTS
// - ACLK         in   1                  clock, rising edge
// - ARESET       in   1                  asynchronous reset, active-high
// - AxVALID      in   1                  master request valid
// - AxREADY      out  1                  queue can accept (= ~full)
// - AxADDR       in   addr_width         request address
// - AxID         in   id_width           request ID
// - AxLEN        in   8                  burst length
// - AxSIZE       in   3                  burst size
// - AxBURST      in   2                  burst type
// - fifo_empty   out  1                  no entry at head; feeds master_fifo_empty[m]
// - slave_dest   out  $clog2(slaves)     head destination; feeds master_slave_dest[m]
// - head_req     out  req_t              head payload {addr,id,len,size,burst,decerr}
// - pop          in   1                  remove head (granted request accepted by slave)
// - count        out  $clog2(depth+1)    occupancy
// - pop_err      out  1                  sticky: pop seen while empty
// BEHAVIOUR
// - Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, fifo_empty=1, AxREADY=1, pop_err=0.
// - Reset also forces slave_dest=0 and head_req=0. Storage contents are don't-care.
// - Push on AxVALID&AxREADY at the rising edge. Entry is visible at the head the next cycle (1-cycle latency).
// - fifo_empty deasserts in that cycle; there is no fall-through.
// - Pop on pop&~fifo_empty: rd_ptr advances and the next entry is visible next cycle.
// - Decode at push: sel = AxADDR[slave_sel_lsb +: $clog2(slaves)].
//   - If sel < slaves: dest = sel, decerr = 0.
//   - If sel >= slaves: dest = slaves-1, decerr = 1 (the downstream slave path returns DECERR).
// - AxREADY = ~full, derived from registered count (no combinational path from pop). A full queue rejects pushes even when pop is asserted.
// - Simultaneous push and pop with 0<count<depth: count unchanged; both pointers advance.
// - Simultaneous push and pop at count 0: only the push takes effect; pop is ignored and pop_err is set.
// - Pointers are $clog2(depth) bits and wrap naturally at depth-1 -> 0. count distinguishes full from empty.
// - pop_err stays set until reset.
// - Outputs are stable while fifo_empty=1. head_req and slave_dest are held between pops.
// - Reset mid-transfer drops all entries. No handshake is owed on a dropped entry.
// STRUCTURE
// - xbar_pkg:
//   - localparams AXI_LEN_W=8, AXI_SIZE_W=3, AXI_BURST_W=2
//   - typedef req_t (packed struct above, parameterised via pkg widths)
//   - function dest_width(slaves)
// - Sub-module slave_address_decoder (combinational): addr -> {dest, decerr}.
//   Reused by the read-side instance; one instance for AW, one for AR.
// - Storage: flop array depth x (req_t + dest).
// TESTING
// 1. Reset: assert ARESET mid-cycle -> fifo_empty=1, AxREADY=1, count=0 immediately, without waiting for an edge.
// 2. Single push: ADDR=0x1000_0040, ID=3, slaves=2 -> next cycle fifo_empty=0, slave_dest=1, count=1.
//    Then pop -> fifo_empty=1 the following cycle.
// 3. Fill: push 4 with no pop -> count=4, AxREADY=0.
//    A 5th valid is held off. Pop 1 -> AxREADY=1 the next cycle, and the held request is accepted.
// 4. Wrap: push/pop 10 requests with IDs 0..9 at count 2 steady -> IDs pop in order, count stays 2, pointers wrap twice.
// 5. Decode error: slaves=3, ADDR=0xF000_0000 (sel=3) -> slave_dest=2, head_req.decerr=1.
// 6. Pop on empty, same cycle as push -> push lands (count=1), pop_err=1 and stays 1 until ARESET.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared crossbar types: AXI field widths, address-channel request payload, dest width helper.
// No logic, no latency.
// No flow control; types only.
package xbar_pkg;

  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_ID_W    = 4;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;

  // Head payload presented to the forward arbiters; decerr routes the request to the error path
  typedef struct packed {
    logic [AXI_ADDR_W-1:0]  addr;
    logic [AXI_ID_W-1:0]    id;
    logic [AXI_LEN_W-1:0]   len;
    logic [AXI_SIZE_W-1:0]  size;
    logic [AXI_BURST_W-1:0] burst;
    logic                   decerr;
  } req_t;

  // A single-slave crossbar still carries a 1-bit destination field
  function automatic int dest_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slave_address_decoder.sv
// Maps the slave-select address field to a destination slave index and a decode-error flag.
// Combinational, zero latency.
// No flow control; caller supplies only the select field.
module slave_address_decoder
  import xbar_pkg::*;
#(
  parameter int slaves = 2
) (
  input  logic [dest_width(slaves)-1:0] i_sel,
  output logic [dest_width(slaves)-1:0] o_dest,
  output logic                          o_decerr
);

  localparam int DW = dest_width(slaves);

  // Unmapped select values are steered to the last slave, whose path answers DECERR
  assign o_decerr = (32'(i_sel) >= 32'(slaves));
  assign o_dest   = o_decerr ? DW'(slaves - 1) : i_sel;

endmodule

// File: rtl/master_request_fifo.sv
// Per-master AXI address request queue with push-time slave decode, head fed to all forward arbiters.
// Push visible at head one cycle later (no fall-through); pop advances head one cycle later.
// AxREADY = ~full from registered count only; a full queue refuses pushes even while popping.
module master_request_fifo
  import xbar_pkg::*;
#(
  parameter int slaves        = 2,
  parameter int depth         = 4,
  parameter int addr_width    = AXI_ADDR_W,
  parameter int id_width      = AXI_ID_W,
  parameter int slave_sel_lsb = 28
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          AxVALID,
  output logic                          AxREADY,
  input  logic [addr_width-1:0]         AxADDR,
  input  logic [id_width-1:0]           AxID,
  input  logic [AXI_LEN_W-1:0]          AxLEN,
  input  logic [AXI_SIZE_W-1:0]         AxSIZE,
  input  logic [AXI_BURST_W-1:0]        AxBURST,
  output logic                          fifo_empty,
  output logic [dest_width(slaves)-1:0] slave_dest,
  output req_t                          head_req,
  input  logic                          pop,
  output logic [$clog2(depth+1)-1:0]    count,
  output logic                          pop_err
);

  localparam int DW = dest_width(slaves);
  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_pop_err;
  req_t          r_head_req;
  logic [DW-1:0] r_head_dest;
  req_t          r_mem_req  [depth];
  logic [DW-1:0] r_mem_dest [depth];

  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_left;
  req_t          w_new_req;
  logic [DW-1:0] w_new_dest;
  logic          w_new_decerr;
  req_t          w_head_req_nxt;
  logic [DW-1:0] w_head_dest_nxt;

  assign fifo_empty   = (r_count == '0);
  assign AxREADY      = (r_count != CW'(depth));
  assign w_push       = AxVALID & AxREADY;
  assign w_pop        = pop & ~fifo_empty;
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
  assign w_left       = r_count - CW'(w_pop);

  slave_address_decoder #(
    .slaves (slaves)
  ) u_decoder (
    .i_sel    (AxADDR[slave_sel_lsb +: DW]),
    .o_dest   (w_new_dest),
    .o_decerr (w_new_decerr)
  );

  assign w_new_req = '{addr: AxADDR, id: AxID, len: AxLEN, size: AxSIZE,
                       burst: AxBURST, decerr: w_new_decerr};

  // Next head: surviving entry after the pop, else the entry being pushed into an empty queue, else hold
  always_comb begin
    w_head_req_nxt  = r_head_req;
    w_head_dest_nxt = r_head_dest;
    if (w_left != '0) begin
      w_head_req_nxt  = r_mem_req[w_rd_ptr_nxt];
      w_head_dest_nxt = r_mem_dest[w_rd_ptr_nxt];
    end else if (w_push) begin
      w_head_req_nxt  = w_new_req;
      w_head_dest_nxt = w_new_dest;
    end
  end

  // Storage array is not reset; only entries between the pointers are ever read
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem_req[r_wr_ptr]  <= w_new_req;
      r_mem_dest[r_wr_ptr] <= w_new_dest;
    end
  end

  // Pointers, occupancy, sticky pop error and registered head outputs
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pop_err   <= 1'b0;
      r_head_req  <= '0;
      r_head_dest <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= r_count + CW'(w_push) - CW'(w_pop);
      if (pop && fifo_empty) r_pop_err <= 1'b1;
      r_head_req  <= w_head_req_nxt;
      r_head_dest <= w_head_dest_nxt;
    end
  end

  assign head_req   = r_head_req;
  assign slave_dest = r_head_dest;
  assign count      = r_count;
  assign pop_err    = r_pop_err;

endmodule

// File: tb/tb_master_request_fifo.sv
`timescale 1ns/1ps
module tb_master_request_fifo;
  import xbar_pkg::*;

  logic        ACLK;
  logic        ARESET;
  logic        AxVALID;
  logic [31:0] AxADDR;
  logic [3:0]  AxID;
  logic [7:0]  AxLEN;
  logic [2:0]  AxSIZE;
  logic [1:0]  AxBURST;
  logic        pop;

  logic        rdy2, emp2, perr2;
  logic [0:0]  dest2;
  req_t        head2;
  logic [2:0]  cnt2;
  logic        rdy3, emp3, perr3;
  logic [1:0]  dest3;
  req_t        head3;
  logic [2:0]  cnt3;

  int checks = 0;
  int errors = 0;

  // Two instances on the same stimulus: a 2-slave crossbar and a 3-slave one with an unmapped select
  master_request_fifo #(.slaves(2), .depth(4)) u_dut2 (
    .ACLK(ACLK), .ARESET(ARESET), .AxVALID(AxVALID), .AxREADY(rdy2), .AxADDR(AxADDR),
    .AxID(AxID), .AxLEN(AxLEN), .AxSIZE(AxSIZE), .AxBURST(AxBURST), .fifo_empty(emp2),
    .slave_dest(dest2), .head_req(head2), .pop(pop), .count(cnt2), .pop_err(perr2));

  master_request_fifo #(.slaves(3), .depth(4)) u_dut3 (
    .ACLK(ACLK), .ARESET(ARESET), .AxVALID(AxVALID), .AxREADY(rdy3), .AxADDR(AxADDR),
    .AxID(AxID), .AxLEN(AxLEN), .AxSIZE(AxSIZE), .AxBURST(AxBURST), .fifo_empty(emp3),
    .slave_dest(dest3), .head_req(head3), .pop(pop), .count(cnt3), .pop_err(perr3));

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          dest2;
    int          dest3;
    bit          derr3;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   mcount;
  bit   mperr;
  bit   acc_push, acc_pop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected decode from the address select field, evaluated per crossbar size
  function automatic exp_t make_exp(input logic [31:0] a, input logic [3:0] id,
                                    input logic [7:0] len, input logic [2:0] size,
                                    input logic [1:0] burst);
    exp_t x;
    int s2, s3;
    s2 = int'(a >> 28) % 2;
    s3 = int'(a >> 28) % 4;
    x.addr = a; x.id = id; x.len = len; x.size = size; x.burst = burst;
    x.dest2 = s2;
    x.dest3 = (s3 < 3) ? s3 : 2;
    x.derr3 = (s3 >= 3);
    return x;
  endfunction

  // Reference model: queue of accepted requests, occupancy and sticky pop error
  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      exp_q.delete();
      mcount = 0;
      mperr  = 1'b0;
    end else begin
      acc_push = AxVALID && (mcount < 4);
      acc_pop  = pop && (mcount > 0);
      if (pop && mcount == 0) mperr = 1'b1;
      if (acc_push) exp_q.push_back(make_exp(AxADDR, AxID, AxLEN, AxSIZE, AxBURST));
      mcount = mcount + int'(acc_push) - int'(acc_pop);
    end
  end

  // Monitor: status every cycle, head against scoreboard front whenever the DUT presents an entry
  always @(negedge ACLK) begin
    if (!ARESET) begin
      chk("count2", cnt2, mcount);
      chk("count3", cnt3, mcount);
      chk("ready2", rdy2, mcount < 4);
      chk("ready3", rdy3, mcount < 4);
      chk("empty2", emp2, mcount == 0);
      chk("empty3", emp3, mcount == 0);
      chk("pop_err2", perr2, mperr);
      chk("pop_err3", perr3, mperr);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        chk("head2", 64'(head2), {e.addr, e.id, e.len, e.size, e.burst, 1'b0});
        chk("head3", 64'(head3), {e.addr, e.id, e.len, e.size, e.burst, e.derr3});
        chk("dest2", dest2, e.dest2);
        chk("dest3", dest3, e.dest3);
        if (pop) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] a, input logic [3:0] id, input bit p);
    AxVALID = v;
    AxADDR  = a;
    AxID    = id;
    AxLEN   = 8'($urandom);
    AxSIZE  = 3'($urandom);
    AxBURST = 2'($urandom);
    pop     = p;
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    ARESET = 1'b0; AxVALID = 1'b0; AxADDR = '0; AxID = '0;
    AxLEN = '0; AxSIZE = '0; AxBURST = '0; pop = 1'b0;
    #1 ARESET = 1'b1;
    #1;
    chk("rst_empty", emp2, 1'b1);
    chk("rst_ready", rdy2, 1'b1);
    chk("rst_count", cnt2, 0);
    chk("rst_pop_err", perr2, 1'b0);
    chk("rst_head", 64'(head3), 0);
    chk("rst_dest", dest3, 0);
    @(posedge ACLK); #1 ARESET = 1'b0;
    drive(0, 0, 0, 0);

    // single push then pop
    drive(1, 32'h1000_0040, 4'd3, 0);
    chk("t2_empty", emp2, 1'b0);
    chk("t2_dest", dest2, 1);
    chk("t2_count", cnt2, 1);
    drive(0, 0, 0, 1);
    chk("t2_popped", emp2, 1'b1);

    // fill, hold off a fifth request, release with one pop
    for (int i = 0; i < 4; i++) drive(1, $urandom, 4'(i), 0);
    chk("t3_full_count", cnt2, 4);
    chk("t3_full_ready", rdy2, 1'b0);
    drive(1, 32'h0000_0500, 4'd4, 0);
    drive(1, 32'h0000_0500, 4'd4, 0);
    chk("t3_held_count", cnt2, 4);
    drive(1, 32'h0000_0500, 4'd4, 1);
    chk("t3_pop_count", cnt2, 3);
    chk("t3_pop_ready", rdy2, 1'b1);
    drive(1, 32'h0000_0500, 4'd4, 0);
    chk("t3_accept_count", cnt2, 4);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
    chk("t3_drained", emp2, 1'b1);

    // steady count 2 with wrapping pointers
    drive(1, $urandom, 4'd0, 0);
    drive(1, $urandom, 4'd1, 0);
    for (int i = 2; i < 10; i++) begin
      drive(1, $urandom, 4'(i), 1);
      chk("t4_steady_count", cnt2, 2);
    end
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    chk("t4_drained", emp2, 1'b1);

    // unmapped select on the 3-slave instance
    drive(1, 32'hF000_0000, 4'd5, 0);
    chk("t5_dest3", dest3, 2);
    chk("t5_decerr3", head3.decerr, 1'b1);
    chk("t5_dest2", dest2, 1);
    chk("t5_decerr2", head2.decerr, 1'b0);
    drive(0, 0, 0, 1);

    // pop on empty together with a push
    drive(1, $urandom, 4'd6, 1);
    chk("t6_count", cnt2, 1);
    chk("t6_pop_err", perr2, 1'b1);
    repeat (3) drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    chk("t6_pop_err_sticky", perr3, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), $urandom, 4'($urandom), 1'($urandom_range(0, 1)));

    // asynchronous reset asserted mid-cycle with entries queued
    drive(0, 0, 0, 0);
    drive(1, $urandom, 4'd7, 0);
    drive(1, $urandom, 4'd8, 0);
    AxVALID = 1'b0;
    #3 ARESET = 1'b1;
    #1;
    chk("mid_rst_empty", emp2, 1'b1);
    chk("mid_rst_ready", rdy3, 1'b1);
    chk("mid_rst_count", cnt3, 0);
    chk("mid_rst_pop_err", perr2, 1'b0);
    @(posedge ACLK); #1 ARESET = 1'b0;
    for (int i = 0; i < 50; i++)
      drive(1'($urandom_range(0, 1)), $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
    drive(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
